pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, segment-pipelined two's-complement adder/subtractor for the CORDIC datapath.
- Generalises the fixed-width ripple adders to any WIDTH, using the same sub-select convention: b is inverted and carry-in is 1 when subtracting.
- The carry chain is cut into SEG_W-bit segments with a register between segments, so the block closes timing at wide widths.
- Valid/ready handshake on both sides with full backpressure; sits between the CORDIC iteration control and the x/y/z accumulators.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 2.
- SEG_W, 8, segment width in bits; WIDTH must be a multiple of SEG_W. NSEG = WIDTH/SEG_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a-b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  final carry XOR sub; for subtract, 1 means borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Reset, clock and reset handling: one clock, clk. rst is asynchronous and active-high and clears every valid bit immediately.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0. After reset deasserts, in_ready=1.
- Data registers in the pipeline need not be reset; only the valid bits are.
- Accept: an operand set is taken when in_valid && in_ready. The block captures a, b^{WIDTH{sub}} and carry-in=sub.
- Stage k (0..NSEG-1):
  - adds segment k of the captured operands plus the carry registered from stage k-1 (stage 0 uses sub);
  - registers the SEG_W-bit partial sum and the carry-out.
- Skew handling: not-yet-added upper segments are delayed alongside, and already-added lower segment sums are carried forward, so sum is aligned at the output.
- Latency: exactly NSEG cycles from the accepting edge to out_valid=1 when out_ready is held high.
- Throughput: 1 result per cycle.
- Stall: the whole pipeline advances only when adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=0 every stage register, valid bit and output holds its value.
  - Bubbles are not compressed; one global enable is used.
- Output: cout = final carry ^ sub.
  - ovf = (a[W-1] == b'[W-1]) && (raw_sum[W-1] != a[W-1]), where b' is the inverted-if-sub operand.
  - Sign bits are carried through the pipeline for this.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Simultaneous accept and output handshake in the same cycle is legal; the pipeline simply shifts.
- in_valid=0 inserts a bubble, i.e. a valid bit of 0.
- Wrap-around: results are modulo 2^WIDTH unless SATURATE_EN applies.
- out_valid=1 with out_ready=0 holds sum, cout and ovf stable until accepted.
- Reset mid-operation: all in-flight results are discarded; none appears after rst deasserts.
- NSEG=1 degenerates to a single-register adder with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SATURATE_EN.
- Defined: when ovf=1, sum is clamped.
  - Positive overflow (a sign 0) gives 2^(W-1)-1; negative overflow gives -2^(W-1).
  - ovf and cout are still reported unchanged.
  - The clamp is applied in the output register stage, so latency is unchanged.
- Undefined: sum is always the wrapped result and no clamp logic exists.

Test Plan:
- WIDTH=32, SEG_W=8: a=5, b=3, sub=0, out_ready=1 -> after 4 cycles sum=0x00000008, cout=0, ovf=0.
- a=0xFFFFFFFF, b=1, add -> sum=0x00000000, cout=1, ovf=0; the carry crosses all 4 segments.
- a=3, b=5, sub=1 -> sum=0xFFFFFFFE, cout=1 (borrow), ovf=0. Then a=5, b=3, sub=1 -> sum=2, cout=0.
- a=0x7FFFFFFF, b=1, add -> ovf=1, sum=0x80000000; with PIPELINED_ADDSUB_SATURATE_EN sum=0x7FFFFFFF. Also a=0x80000000, b=1, sub=1 -> saturated sum=0x80000000, ovf=1.
- 16 back-to-back random ops, in_valid with random gaps, out_ready random 50% -> results match the reference model in order; outputs stable while stalled; no accept while in_ready=0.
- Fill the pipeline with 4 ops, assert rst asynchronously mid-cycle -> out_valid=0 immediately; after release no stale result appears; the next op returns correctly after 4 cycles. Also run WIDTH=6, SEG_W=2 and WIDTH=8, SEG_W=8 to check parametrisation.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Segment-pipelined two's-complement adder/subtractor with valid/ready flow control.
// Optional output clamp on signed overflow: define PIPELINED_ADDSUB_SATURATE_EN.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG_W;

    // Stage k holds operands (full width, upper segments still pending), the
    // partial sum of segments below k and the carry into segment k.
    logic             adv_s;
    logic [NSEG-1:0]  v_r;
    logic [NSEG-1:0]  c_r;
    logic [NSEG-1:0]  sub_r;
    logic [WIDTH-1:0] a_r [NSEG];
    logic [WIDTH-1:0] b_r [NSEG];
    logic [WIDTH-1:0] s_r [NSEG];

    logic [NSEG-1:0]  c_s;
    logic [NSEG-1:0]  sub_s;
    logic [WIDTH-1:0] a_s [NSEG];
    logic [WIDTH-1:0] b_s [NSEG];
    logic [WIDTH-1:0] s_s [NSEG];
    logic [SEG_W:0]   seg_s [NSEG];
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             ovf_s;

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    // Segment adders: stage k adds segment k with its registered carry-in.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            seg_s[k] = {1'b0, a_r[k][k*SEG_W +: SEG_W]}
                     + {1'b0, b_r[k][k*SEG_W +: SEG_W]}
                     + {{SEG_W{1'b0}}, c_r[k]};
        end
    end

    // Next-stage values: capture at stage 0, shift with merged partial sum above.
    always_comb begin
        a_s[0]   = a;
        b_s[0]   = b ^ {WIDTH{sub}};
        c_s[0]   = sub;
        sub_s[0] = sub;
        s_s[0]   = {WIDTH{1'b0}};
        for (int k = 1; k < NSEG; k++) begin
            a_s[k]   = a_r[k-1];
            b_s[k]   = b_r[k-1];
            c_s[k]   = seg_s[k-1][SEG_W];
            sub_s[k] = sub_r[k-1];
            s_s[k]   = s_r[k-1];
            s_s[k][(k-1)*SEG_W +: SEG_W] = seg_s[k-1][SEG_W-1:0];
        end
    end

    // Final segment completes the result; flags use the carried sign bits.
    always_comb begin
        raw_s = s_r[NSEG-1];
        raw_s[(NSEG-1)*SEG_W +: SEG_W] = seg_s[NSEG-1][SEG_W-1:0];
        cout_s = seg_s[NSEG-1][SEG_W] ^ sub_r[NSEG-1];
        ovf_s  = (a_r[NSEG-1][WIDTH-1] == b_r[NSEG-1][WIDTH-1])
              && (raw_s[WIDTH-1] != a_r[NSEG-1][WIDTH-1]);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (ovf_s) begin
            sum_s = {a_r[NSEG-1][WIDTH-1], {(WIDTH-1){!a_r[NSEG-1][WIDTH-1]}}};
        end else begin
            sum_s = raw_s;
        end
`else
        sum_s = raw_s;
`endif
    end

    // Pipeline data registers; unreset, advance on the global enable.
    always_ff @(posedge clk) begin
        if (adv_s) begin
            for (int k = 0; k < NSEG; k++) begin
                a_r[k]   <= a_s[k];
                b_r[k]   <= b_s[k];
                s_r[k]   <= s_s[k];
                c_r[k]   <= c_s[k];
                sub_r[k] <= sub_s[k];
            end
        end
    end

    // Valid bits; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r       <= {NSEG{1'b0}};
            out_valid <= 1'b0;
        end else if (adv_s) begin
            v_r[0] <= in_valid;
            for (int k = 1; k < NSEG; k++) begin
                v_r[k] <= v_r[k-1];
            end
            out_valid <= v_r[NSEG-1];
        end
    end

    // Output register; loads only real results so bubbles never disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= {WIDTH{1'b0}};
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv_s && v_r[NSEG-1]) begin
            sum  <= sum_s;
            cout <= cout_s;
            ovf  <= ovf_s;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: 32/8 main instance plus 6/2 and 8/8 instances.
`timescale 1ns/1ps
module tb_pipelined_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIPELINED_ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    pipelined_addsub #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));

    logic       iv6, ir6, sub6, ov6, c6, o6;
    logic [5:0] a6, b6, s6;
    pipelined_addsub #(.WIDTH(6), .SEG_W(2)) dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6),
        .a(a6), .b(b6), .sub(sub6), .out_valid(ov6), .out_ready(1'b1),
        .sum(s6), .cout(c6), .ovf(o6));

    logic       iv8, ir8, sub8, ov8, c8, o8;
    logic [7:0] a8, b8, s8;
    pipelined_addsub #(.WIDTH(8), .SEG_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(ov8), .out_ready(1'b1),
        .sum(s8), .cout(c8), .ovf(o8));

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        lat;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic [31:0] rs;
        logic        c;
        logic        o;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[12];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    bit          lat_mode, rnd_ready, ready_fix;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t hand_exp(input vec_t v);
        exp_t e;
        e.sum  = SAT ? v.rs : v.r;
        e.cout = v.c;
        e.ovf  = v.o;
        e.lat  = 1'b0;
        e.cyc  = 0;
        return e;
    endfunction

    // Reference from signed/unsigned arithmetic semantics, for random operands.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t        e;
        logic [32:0] sx;
        logic [32:0] u;
        sx = s ? ({x[31], x} - {y[31], y}) : ({x[31], x} + {y[31], y});
        u  = {1'b0, x} + {1'b0, y};
        e.ovf  = sx[32] != sx[31];
        e.cout = s ? (x < y) : u[32];
        e.sum  = (SAT && e.ovf) ? (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sx[31:0];
        e.lat  = 1'b0;
        e.cyc  = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds the operand until the handshake completes.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input exp_t e);
        bit done = 1'b0;
        a = x; b = y; sub = s; in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.cyc = cyc;
                e.lat = lat_mode;
                sbq.push_back(e);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sbq.size() != 0; t++) tick();
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks stall stability.
    logic        held;
    logic [34:0] held_val;
    initial held = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) chk("stall_stable", {out_valid, sum, cout, ovf}, held_val);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                    chk("ovf", ovf, e.ovf);
                    if (e.lat) chk("latency", cyc - e.cyc, 5);
                end
            end
            held     = out_valid && !out_ready;
            held_val = {out_valid, sum, cout, ovf};
        end
    end

    task automatic run6(input logic [5:0] x, input logic [5:0] y, input logic s,
                        input logic [5:0] es, input logic ec, input logic eo);
        int lat = 0;
        a6 = x; b6 = y; sub6 = s; iv6 = 1'b1;
        tick();
        iv6 = 1'b0;
        for (int t = 1; t <= 10 && lat == 0; t++) begin
            @(negedge clk);
            if (ov6) begin
                lat = t - 1;
                chk("w6_sum", s6, es);
                chk("w6_cout", c6, ec);
                chk("w6_ovf", o6, eo);
            end
        end
        chk("w6_latency", lat, 3);
        tick();
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo);
        int lat = 0;
        a8 = x; b8 = y; sub8 = s; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        for (int t = 1; t <= 10 && lat == 0; t++) begin
            @(negedge clk);
            if (ov8) begin
                lat = t - 1;
                chk("w8_sum", s8, es);
                chk("w8_cout", c8, ec);
                chk("w8_ovf", o8, eo);
            end
        end
        chk("w8_latency", lat, 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        iv6 = 1'b0; a6 = '0; b6 = '0; sub6 = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        ready_fix = 1'b1; rnd_ready = 1'b0; lat_mode = 1'b1;

        vecs[0]  = '{32'd5,         32'd3,         1'b0, 32'd8,         32'd8,         1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0,         32'h0,         1'b1, 1'b0};
        vecs[2]  = '{32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[3]  = '{32'd5,         32'd3,         1'b1, 32'd2,         32'd2,         1'b0, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[5]  = '{32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
        vecs[6]  = '{32'h00FF_00FF, 32'h0001_0F01, 1'b0, 32'h0100_1000, 32'h0100_1000, 1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0,         32'h8000_0000, 1'b1, 1'b1};
        vecs[8]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[9]  = '{32'd0,         32'd1,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[11] = '{32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        tick();

        // Directed, back-to-back, consumer always ready: exact latency checked.
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].s, hand_exp(vecs[i]));
        drain();

        // Same vectors with input gaps and random backpressure.
        lat_mode = 1'b0; rnd_ready = 1'b1;
        foreach (vecs[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            send(vecs[i].a, vecs[i].b, vecs[i].s, hand_exp(vecs[i]));
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] x, y;
            logic        s;
            x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 1)) tick();
            send(x, y, s, model(x, y, s));
        end
        drain();
        rnd_ready = 1'b0; ready_fix = 1'b1;
        tick();

        // Fill under backpressure, then reset asynchronously mid-cycle.
        ready_fix = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send(vecs[i].a, vecs[i].b, vecs[i].s, hand_exp(vecs[i]));
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        chk("fill_out_valid", out_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        sbq.delete();
        tick();
        rst = 1'b0;
        ready_fix = 1'b1;
        stale = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale_after_rst", stale, 0);
        tick();
        lat_mode = 1'b1;
        send(32'd5, 32'd3, 1'b0, hand_exp(vecs[0]));
        drain();

        // Other parametrisations, one op at a time.
        run6(6'h3F, 6'h01, 1'b0, 6'h00, 1'b1, 1'b0);
        run6(6'h1F, 6'h01, 1'b0, SAT ? 6'h1F : 6'h20, 1'b0, 1'b1);
        run6(6'h03, 6'h05, 1'b1, 6'h3E, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1);
        run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0);
        run8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
